button_event: RTL

Classifies the single-cycle pulse train produced by the debouncer into user-level button events: press, click, long press, auto-repeat and release. While a button is held, the debouncer emits one pulse every P clocks; this block detects the start and end of that train and times it in pulses. It sits directly downstream of the debouncer and feeds menu, counter and display logic on the 50 MHz domain.

---
 rtl/button_event.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/button_event.sv
// Turns the debouncer's pulse train into press, click, long-press,
// auto-repeat and release events, plus a held level and press counter.
module button_event #(
    parameter int unsigned GAP    = 8,
    parameter int unsigned LONG   = 4,
    parameter int unsigned REPEAT = 2
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       tick,
    output logic       press,
    output logic       long_press,
    output logic       repeat_evt,
    output logic       release_evt,
    output logic       click,
    output logic       held,
    output logic [7:0] press_count
);

    function automatic int clog2(input int unsigned v);
        int r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    localparam int GW = clog2(GAP + 1);
    localparam int TW = clog2(LONG + 1);
    localparam int RW = clog2(REPEAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG_ST = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    logic       press_q, press_d;
    logic       long_q, long_d;
    logic       rep_q, rep_d;
    logic       rel_q, rel_d;
    logic       click_q, click_d;
    logic       held_q, held_d;
    logic [7:0] pcnt_q, pcnt_d;

    logic gap_hit;
    logic long_hit;
    logic rep_hit;

    // A tick on the cycle the gap would expire keeps the train alive.
    assign gap_hit  = !tick && (gap_cnt_q == GW'(GAP - 1));
    assign long_hit = tick && (tick_cnt_q == TW'(LONG - 1));
    assign rep_hit  = tick && (rep_cnt_q == RW'(REPEAT - 1));

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            tick_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
            rel_q      <= 1'b0;
            click_q    <= 1'b0;
            held_q     <= 1'b0;
            pcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
            rel_q      <= rel_d;
            click_q    <= click_d;
            held_q     <= held_d;
            pcnt_q     <= pcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        tick_cnt_d = tick_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        if (tick) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GW'(GAP)) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    tick_cnt_d = TW'(1);
                    state_d    = SHORT;
                end
            end
            SHORT: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                    if (long_hit) begin
                        rep_cnt_d = '0;
                        state_d   = LONG_ST;
                    end
                end else if (gap_hit) begin
                    state_d = IDLE;
                end
            end
            LONG_ST: begin
                if (tick) begin
                    rep_cnt_d = rep_hit ? '0 : rep_cnt_q + RW'(1);
                end else if (gap_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d = (state_q == IDLE) && tick;
        long_d  = (state_q == SHORT) && long_hit;
        rep_d   = (state_q == LONG_ST) && rep_hit;
        rel_d   = (state_q != IDLE) && gap_hit;
        click_d = (state_q == SHORT) && gap_hit;
        held_d  = (state_d != IDLE) || rel_d;
        pcnt_d  = press_d ? pcnt_q + 8'd1 : pcnt_q;
    end

    assign press       = press_q;
    assign long_press  = long_q;
    assign repeat_evt  = rep_q;
    assign release_evt = rel_q;
    assign click       = click_q;
    assign held        = held_q;
    assign press_count = pcnt_q;

endmodule
